// File: rtl/div_unit.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU): restoring radix-2, 34-cycle normal path,
// single-cycle path for divide-by-zero and signed overflow. All outputs registered.
`timescale 1ns/1ps
module div_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] srca,
  input  logic [XLEN-1:0] srcb,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            we
);

  localparam int unsigned CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   count;
  logic [XLEN:0]   prem;
  logic [XLEN-1:0] dvd;
  logic [XLEN-1:0] dvs;
  logic            neg_q;
  logic            neg_r;
  logic            rem_sel;

  logic            op_signed;
  logic            op_rem;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_abs;
  logic [XLEN-1:0] b_abs;
  logic            div_zero;
  logic            overflow;
  logic [XLEN-1:0] special_res;
  logic [XLEN:0]   p_shift;
  logic            q_bit;
  logic [XLEN:0]   p_next;
  logic [XLEN-1:0] q_fix;
  logic [XLEN-1:0] r_fix;

  // Operand decode and special-case detection at accept; codes 0xx fall back to DIVU.
  always_comb begin
    op_signed   = funct3[2] & ~funct3[0];
    op_rem      = funct3[2] & funct3[1];
    a_neg       = op_signed & srca[XLEN-1];
    b_neg       = op_signed & srcb[XLEN-1];
    a_abs       = a_neg ? XLEN'(-srca) : srca;
    b_abs       = b_neg ? XLEN'(-srcb) : srcb;
    div_zero    = (srcb == '0);
    overflow    = op_signed && (srca == {1'b1, {(XLEN-1){1'b0}}}) && (srcb == '1);
    special_res = '0;
    if (div_zero) begin
      special_res = op_rem ? srca : '1;
    end else if (overflow) begin
      special_res = op_rem ? '0 : srca;
    end
  end

  // One restoring step: dividend shifts out MSB-first while quotient bits shift in at the LSB.
  always_comb begin
    p_shift = {prem[XLEN-1:0], dvd[XLEN-1]};
    q_bit   = (p_shift >= {1'b0, dvs});
    p_next  = q_bit ? (XLEN+1)'(p_shift - {1'b0, dvs}) : p_shift;
    q_fix   = neg_q ? XLEN'(-dvd) : dvd;
    r_fix   = neg_r ? XLEN'(-prem[XLEN-1:0]) : prem[XLEN-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      count   <= '0;
      prem    <= '0;
      dvd     <= '0;
      dvs     <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      rem_sel <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      we      <= 1'b0;
      result  <= '0;
      rd_out  <= '0;
    end else begin
      done <= 1'b0;
      we   <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !flush) begin
            rd_out  <= rd_in;
            rem_sel <= op_rem;
            busy    <= 1'b1;
            if (div_zero || overflow) begin
              result <= special_res;
              done   <= 1'b1;
              we     <= (rd_in != 5'd0);
              state  <= DONE;
            end else begin
              count <= '0;
              prem  <= '0;
              dvd   <= a_abs;
              dvs   <= b_abs;
              neg_q <= a_neg ^ b_neg;
              neg_r <= a_neg;
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (flush) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            prem  <= p_next;
            dvd   <= {dvd[XLEN-2:0], q_bit};
            count <= count + CW'(1);
            if (count == CW'(XLEN - 1)) begin
              state <= FIXUP;
            end
          end
        end
        FIXUP: begin
          if (flush) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            result <= rem_sel ? r_fix : q_fix;
            done   <= 1'b1;
            we     <= (rd_out != 5'd0);
            state  <= DONE;
          end
        end
        DONE: begin
          // Writeback is committed here, so flush is deliberately ignored.
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: cycle-accurate arithmetic/latency model checked every cycle,
// plus directed vectors with literal expected results and latencies.
`timescale 1ns/1ps
module tb_div_unit;

  logic        clk = 1'b0;
  logic        reset, start, flush;
  logic [2:0]  funct3;
  logic [31:0] srca, srcb;
  logic [4:0]  rd_in;
  logic        busy, done, we;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

  div_unit #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3), .srca(srca), .srcb(srcb),
    .rd_in(rd_in), .flush(flush), .busy(busy), .done(done), .result(result),
    .rd_out(rd_out), .we(we)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [31:0] ref_div(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic sgn;
    logic rem;
    sgn = f[2] & ~f[0];
    rem = f[2] & f[1];
    if (b == 32'd0) return rem ? a : 32'hFFFF_FFFF;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? 32'd0 : 32'h8000_0000;
    if (sgn) return rem ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    return rem ? (a % b) : (a / b);
  endfunction

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (f[2] && !f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Model: a request occupies `m_left` more cycles before its done cycle; result becomes visible there.
  bit          m_valid = 1'b0;
  bit          m_active = 1'b0;
  int          m_left = 0;
  logic [31:0] m_hold = '0, m_pend = '0;
  logic [4:0]  m_rd = '0;

  always @(negedge clk) begin
    logic [39:0] exp_v, act_v;
    logic        e_done;
    if (m_valid) begin
      e_done = m_active && (m_left == 0);
      exp_v  = {m_active, e_done, e_done && (m_rd != 5'd0), m_rd, m_hold};
      act_v  = {busy, done, we, rd_out, result};
      n_vec++;
      if (act_v !== exp_v) begin
        n_err++;
        $display("FAIL cycle@%0t: got busy=%b done=%b we=%b rd=%0d res=%h, want busy=%b done=%b we=%b rd=%0d res=%h",
                 $time, busy, done, we, rd_out, result,
                 exp_v[39], exp_v[38], exp_v[37], exp_v[36:32], exp_v[31:0]);
      end
    end
    if (reset) begin
      m_valid  = 1'b1;
      m_active = 1'b0;
      m_left   = 0;
      m_hold   = '0;
      m_rd     = '0;
    end else if (m_active) begin
      if (m_left == 0) m_active = 1'b0;
      else if (flush) m_active = 1'b0;
      else begin
        m_left--;
        if (m_left == 0) m_hold = m_pend;
      end
    end else if (start && !flush) begin
      m_active = 1'b1;
      m_rd     = rd_in;
      m_pend   = ref_div(funct3, srca, srcb);
      if (is_special(funct3, srca, srcb)) begin
        m_left = 0;
        m_hold = m_pend;
      end else begin
        m_left = 33;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!busy) return;
    end
    n_vec++;
    n_err++;
    $display("FAIL idle_timeout: busy=%b, want 0", busy);
  endtask

  // Drive one start pulse; returns just after the accepting edge.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    wait_idle();
    @(posedge clk);
    #1;
    start = 1'b1; funct3 = f; srca = a; srcb = b; rd_in = rd;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int offset, input int exp_lat,
                           input logic [31:0] exp_res, input logic [4:0] exp_rd);
    int lat;
    logic [31:0] r;
    logic [4:0] ro;
    logic w;
    lat = -1; r = 'x; ro = 'x; w = 'x;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k + offset; r = result; ro = rd_out; w = we;
        break;
      end
    end
    chk({name, " latency"}, 32'(lat), 32'(exp_lat));
    chk({name, " result"}, r, exp_res);
    chk({name, " rd_out"}, 32'(ro), 32'(exp_rd));
    chk({name, " we"}, 32'(w), 32'(exp_rd != 5'd0));
  endtask

  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp_res, input int exp_lat);
    issue(f, a, b, rd);
    wait_done(name, 0, exp_lat, exp_res, rd);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; flush = 1'b0;
    funct3 = '0; srca = '0; srcb = '0; rd_in = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset result", result, 32'd0);
    chk("reset rd_out", 32'(rd_out), 32'd0);

    run_op("divu 100/7",   F_DIVU, 32'd100,        32'd7,          5'd5,  32'd14,         34);
    run_op("remu 100/7",   F_REMU, 32'd100,        32'd7,          5'd5,  32'd2,          34);
    run_op("div -7/2",     F_DIV,  32'hFFFF_FFF9,  32'd2,          5'd1,  32'hFFFF_FFFD,  34);
    run_op("rem -7/2",     F_REM,  32'hFFFF_FFF9,  32'd2,          5'd2,  32'hFFFF_FFFF,  34);
    run_op("div 7/-2",     F_DIV,  32'd7,          32'hFFFF_FFFE,  5'd3,  32'hFFFF_FFFD,  34);
    run_op("div -7/-2",    F_DIV,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  5'd11, 32'd3,          34);
    run_op("div 5/0",      F_DIV,  32'd5,          32'd0,          5'd4,  32'hFFFF_FFFF,  1);
    run_op("remu 5/0",     F_REMU, 32'd5,          32'd0,          5'd6,  32'd5,          1);
    run_op("rem min/0",    F_REM,  32'h8000_0000,  32'd0,          5'd7,  32'h8000_0000,  1);
    run_op("div ovf",      F_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  5'd8,  32'h8000_0000,  1);
    run_op("rem ovf",      F_REM,  32'h8000_0000,  32'hFFFF_FFFF,  5'd9,  32'd0,          1);
    run_op("divu rd0",     F_DIVU, 32'd9,          32'd3,          5'd0,  32'd3,          34);
    run_op("f3=000 divu",  3'b000, 32'hFFFF_FFF9,  32'd2,          5'd10, 32'h7FFF_FFFC,  34);
    run_op("divu max/1",   F_DIVU, 32'hFFFF_FFFF,  32'd1,          5'd31, 32'hFFFF_FFFF,  34);
    run_op("remu max/10",  F_REMU, 32'hFFFF_FFFF,  32'd10,         5'd12, 32'd5,          34);

    // A start arriving mid-operation is ignored.
    issue(F_DIVU, 32'd100, 32'd7, 5'd5);
    repeat (9) @(posedge clk);
    #1;
    start = 1'b1; funct3 = F_REMU; srca = 32'd55; srcb = 32'd3; rd_in = 5'd12;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("ignored start", 10, 34, 32'd14, 5'd5);

    // Flush mid-CALC drops the request; a new start is accepted on the very next edge.
    issue(F_DIVU, 32'd1000, 32'd3, 5'd7);
    repeat (19) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    start = 1'b1; funct3 = F_DIVU; srca = 32'd50; srcb = 32'd5; rd_in = 5'd9;
    @(negedge clk);
    chk("flush busy", 32'(busy), 32'd0);
    chk("flush keeps result", result, 32'd14);
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("after flush", 0, 34, 32'd10, 5'd9);

    // Flush has priority over start in IDLE.
    wait_idle();
    @(posedge clk);
    #1;
    start = 1'b1; flush = 1'b1; funct3 = F_DIVU; srca = 32'd8; srcb = 32'd2; rd_in = 5'd3;
    @(posedge clk);
    #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("idle flush busy", 32'(busy), 32'd0);
    chk("idle flush rd_out", 32'(rd_out), 32'd9);

    // Reset mid-CALC clears every output.
    issue(F_DIVU, 32'd77, 32'd7, 5'd4);
    repeat (14) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("midreset busy", 32'(busy), 32'd0);
    chk("midreset result", result, 32'd0);
    chk("midreset rd_out", 32'(rd_out), 32'd0);
    chk("midreset done/we", {30'd0, done, we}, 32'd0);
    run_op("after reset", F_DIVU, 32'd77, 32'd7, 5'd4, 32'd11, 34);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative RV32M divider (DIV, DIVU, REM, REMU) in the core's execute stage. It takes register-file read data as operands and returns a single-cycle writeback request (data, destination, write enable) that drives the register file's write port. Normal operands finish in a fixed 34 cycles. Divide-by-zero and signed overflow finish in 1 cycle. The pipeline stalls on `busy`.

## Interface
- `XLEN`, default 32: operand and result width. Only 32 is supported.
- `clk`  in  1  core clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request a divide. Accepted only when `busy`=0.
- `funct3`  in  3  operation: 100 DIV, 101 DIVU, 110 REM, 111 REMU. Other codes are treated as DIVU.
- `srca`  in  XLEN  dividend (rs1 read data).
- `srcb`  in  XLEN  divisor (rs2 read data).
- `rd_in`  in  5  destination register of the request.
- `flush`  in  1  abort any operation in flight.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse; `result` is valid in this cycle.
- `result`  out  XLEN  quotient or remainder; held until the next accepted start.
- `rd_out`  out  5  destination register, latched at accept.
- `we`  out  1  register-file write enable, equal to `done && rd_out != 0`.

## Operation
- States: IDLE, CALC, FIXUP, DONE. All outputs are registered.
- **Reset** (synchronous, from any state, including mid-CALC):
  - state returns to IDLE;
  - `busy`, `done`, `we` = 0; `result` = 0; `rd_out` = 0;
  - the internal counter and partial remainder are cleared.
- **IDLE, `start`=1:**
  - latch `funct3` and `rd_in`;
  - signed = !funct3[0], rem_sel = funct3[1];
  - for signed ops, latch |srca| and |srcb|, plus the quotient sign (sign(a) XOR sign(b)) and the remainder sign (sign(a));
  - unsigned ops latch the operands unmodified.
- **Special cases, decided at accept** (go IDLE → DONE directly):
  - srcb = 0: quotient = 0xFFFFFFFF; remainder = srca (unmodified).
  - Signed, srca = 0x80000000, srcb = 0xFFFFFFFF: quotient = 0x80000000; remainder = 0.
- **Otherwise** go IDLE → CALC with count = 0 and the 33-bit partial remainder = 0.
- **CALC** (restoring, one quotient bit per cycle, MSB first):
  - P = {P[31:0], dividend MSB};
  - shift the dividend left;
  - if P ≥ {0, divisor}: P -= divisor and the quotient bit = 1, else the bit = 0;
  - after 32 iterations (count 31 → 32) go to FIXUP.
- **FIXUP:** apply the latched signs (two's-complement negate the quotient and/or remainder if the sign bit is set), select quotient or remainder by rem_sel, load `result`, then go to DONE.
- **DONE:** `done`=1 for exactly one cycle; `we` as defined above; the next state is IDLE.
- `start` while `busy`=1 is ignored; nothing is latched. Upstream holds the instruction stalled.
- **Flush:**
  - takes effect in CALC or FIXUP: next state IDLE; `done` and `we` are never asserted for that request; `result` keeps its old value.
  - In DONE, flush has no effect, because the writeback is already committed.
  - In IDLE, flush has priority over `start`: the request is dropped.
- Reset has priority over flush, and flush over start.

## Timing
- Start accepted at rising edge E0:
  - normal path: CALC for cycles 1–32, FIXUP in cycle 33, DONE in cycle 34 (`done` high from E33 to E34);
  - special case: DONE in cycle 1.
- `busy` rises in the cycle after accept and falls in the cycle after DONE. The earliest back-to-back accept is at edge E35 for the normal path, or E2 for a special case.
- `result`, `rd_out` and `we` are stable for the whole DONE cycle, so the register file's falling-edge write captures them mid-cycle. No combinational path exists from inputs to outputs.
- Throughput: one divide per 35 cycles (normal) or per 2 cycles (special case).

## Test plan
- DIVU 100 / 7, rd_in = 5, start at E0 → `done`=1 only in cycle 34; result = 14; rd_out = 5; we = 1. REMU with the same operands → 2.
- DIV 0xFFFFFFF9 / 2 (−7/2) → 0xFFFFFFFD (−3). REM → 0xFFFFFFFF (−1). DIV 7 / 0xFFFFFFFE → 0xFFFFFFFD.
- Divide by zero:
  - DIV 5 / 0 → 0xFFFFFFFF, with `done` in cycle 1;
  - REMU 5 / 0 → 5;
  - REM 0x80000000 / 0 → 0x80000000.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 in cycle 1; REM with the same operands → 0.
- Pipeline interaction:
  - a second `start` at cycle 10 is ignored, and the first result is unchanged;
  - flush at cycle 20 → no `done`, IDLE next cycle, and a new start is accepted immediately;
  - reset at cycle 15 → all outputs 0 on the next cycle.
- rd_in = 0, DIVU 9 / 3 → `done`=1 with result = 3, and `we` = 0.
